// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-port register file with a per-register pending-write scoreboard.
//   Register 0 is hardwired to zero. Reads are combinational and bypass
//   same-cycle writes; when several write ports hit one address, the
//   highest-index port wins. Busy bits are set by alloc (issued producer)
//   and cleared by a write (retiring producer); alloc wins on a tie.
//
// Ports
//   i_clk          clock, all state updates on posedge
//   i_reset        synchronous active-high reset (clears storage and busy)
//   i_rd_addr      NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   o_rd_data      NUM_RD packed read data, bypassed
//   o_rd_busy      per read port: address busy and not written this cycle
//   i_wr_en        per write port enable
//   i_wr_addr      NUM_WR packed write addresses
//   i_wr_data      NUM_WR packed write data
//   i_alloc_en     mark i_alloc_addr pending
//   i_alloc_addr   register being allocated
//   o_busy_vec     registered busy bits, bit r = register r
//   o_wr_conflict  two or more enabled write ports target one nonzero address
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    input  logic                     i_alloc_en,
    input  logic [ADDR_W-1:0]        i_alloc_addr,
    output logic [NUM_REGS-1:0]      o_busy_vec,
    output logic                     o_wr_conflict
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [ADDR_W-1:0]   rd_addr [NUM_RD];
    logic [ADDR_W-1:0]   wr_addr [NUM_WR];

    // Writable/readable register: nonzero and inside the implemented range.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < NUM_REGS);
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) rd_addr[k] = i_rd_addr[k*ADDR_W +: ADDR_W];
        for (int w = 0; w < NUM_WR; w++) wr_addr[w] = i_wr_addr[w*ADDR_W +: ADDR_W];
    end

    // Storage and scoreboard.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy_q <= '0;
            // NOTE: the storage array is reset on purpose: after reset every
            // register must read 0, so this is flop-based, not a RAM macro.
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else begin
            // NOTE: non-blocking assignments; when two ports (or a write and
            // an alloc) hit the same element, the last assignment in program
            // order takes effect. Ascending port order gives highest-index
            // priority, and the alloc placed last makes alloc win over clear.
            for (int w = 0; w < NUM_WR; w++) begin
                if (i_wr_en[w] && addr_ok(wr_addr[w])) begin
                    regs_q[wr_addr[w]] <= i_wr_data[w*DATA_W +: DATA_W];
                    busy_q[wr_addr[w]] <= 1'b0;
                end
            end
            if (i_alloc_en && addr_ok(i_alloc_addr)) begin
                busy_q[i_alloc_addr] <= 1'b1;
            end
        end
    end

    assign o_busy_vec = busy_q;

    // Read ports with same-cycle bypass. Bypass data is suppressed during
    // reset, but a write still masks busy since the producer is retiring.
    always_comb begin
        // NOTE: every output gets a default before any conditional update,
        // so no path leaves a bit unassigned and no latch is inferred.
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic              hit;
            logic [DATA_W-1:0] data;
            hit  = 1'b0;
            data = '0;
            if (addr_ok(rd_addr[k])) begin
                data = regs_q[rd_addr[k]];
                for (int w = 0; w < NUM_WR; w++) begin
                    if (i_wr_en[w] && (wr_addr[w] == rd_addr[k])) begin
                        hit = 1'b1;
                        if (!i_reset) data = i_wr_data[w*DATA_W +: DATA_W];
                    end
                end
                o_rd_busy[k] = busy_q[rd_addr[k]] & ~hit;
            end
            o_rd_data[k*DATA_W +: DATA_W] = data;
        end
    end

    // Any pair of enabled ports on the same nonzero address.
    always_comb begin
        o_wr_conflict = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (i_wr_en[i] && i_wr_en[j] && (wr_addr[i] == wr_addr[j]) &&
                    (wr_addr[i] != '0)) begin
                    o_wr_conflict = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Directed bench for regfile_mp (default parameters). Expected values are
//   pushed into a scoreboard queue as each step is driven and popped when the
//   DUT outputs are sampled, mid-cycle, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int NUM_WR   = 2;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    logic                     i_clk = 1'b0;
    logic                     i_reset;
    logic [NUM_RD*ADDR_W-1:0] i_rd_addr;
    logic [NUM_RD*DATA_W-1:0] o_rd_data;
    logic [NUM_RD-1:0]        o_rd_busy;
    logic [NUM_WR-1:0]        i_wr_en;
    logic [NUM_WR*ADDR_W-1:0] i_wr_addr;
    logic [NUM_WR*DATA_W-1:0] i_wr_data;
    logic                     i_alloc_en;
    logic [ADDR_W-1:0]        i_alloc_addr;
    logic [NUM_REGS-1:0]      o_busy_vec;
    logic                     o_wr_conflict;

    regfile_mp #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_busy(o_rd_busy),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_alloc_en(i_alloc_en), .i_alloc_addr(i_alloc_addr),
        .o_busy_vec(o_busy_vec), .o_wr_conflict(o_wr_conflict)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    task automatic expect_val(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        n_asserts++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    // Step timing: tick() leaves us 1 time unit after a rising edge; inputs are
    // then driven and outputs sampled 2 units later, mid-cycle.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_wr_en    = '0;
        i_wr_addr  = '0;
        i_wr_data  = '0;
        i_alloc_en = 1'b0;
        i_alloc_addr = '0;
    endtask

    task automatic rd(input int k, input int addr);
        i_rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    endtask

    task automatic wr(input int p, input int addr, input logic [DATA_W-1:0] data);
        i_wr_en[p] = 1'b1;
        i_wr_addr[p*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        i_wr_data[p*DATA_W +: DATA_W] = data;
    endtask

    task automatic alloc(input int addr);
        i_alloc_en   = 1'b1;
        i_alloc_addr = ADDR_W'(addr);
    endtask

    function automatic logic [DATA_W-1:0] rdata(input int k);
        return o_rd_data[k*DATA_W +: DATA_W];
    endfunction

    // Drain every pending expectation against the current outputs, in the
    // order they were pushed: rd0 data, rd1 data, rd busy, busy vec, conflict.
    task automatic sample_all();
        #2;
        check(64'(rdata(0)));
        check(64'(rdata(1)));
        check(64'(o_rd_busy));
        check(64'(o_busy_vec));
        check(64'(o_wr_conflict));
    endtask

    task automatic expect_all(input string step, input logic [DATA_W-1:0] d0,
                              input logic [DATA_W-1:0] d1, input logic [1:0] rbusy,
                              input logic [NUM_REGS-1:0] bvec, input logic conf);
        expect_val({step, "_rd0"},      64'(d0));
        expect_val({step, "_rd1"},      64'(d1));
        expect_val({step, "_rd_busy"},  64'(rbusy));
        expect_val({step, "_busy_vec"}, 64'(bvec));
        expect_val({step, "_conflict"}, 64'(conf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset   = 1'b1;
        i_rd_addr = '0;
        idle();

        // Reset, then sweep every address pair.
        tick();
        i_reset = 1'b0;
        for (int a = 0; a < NUM_REGS / 2; a++) begin
            rd(0, 2 * a);
            rd(1, 2 * a + 1);
            expect_all($sformatf("reset_a%0d", 2 * a), '0, '0, 2'b00, '0, 1'b0);
            sample_all();
            tick();
        end

        // Bypass then storage on x5.
        idle(); rd(0, 5); rd(1, 0);
        wr(0, 5, 32'h1234_5678);
        expect_all("bypass_x5", 32'h1234_5678, '0, 2'b00, '0, 1'b0);
        sample_all();
        tick();
        idle();
        expect_all("stored_x5", 32'h1234_5678, '0, 2'b00, '0, 1'b0);
        sample_all();
        tick();

        // Write collision on x7: port 1 wins.
        rd(0, 7); rd(1, 5);
        wr(0, 7, 32'hAAAA_AAAA);
        wr(1, 7, 32'h5555_5555);
        expect_all("conflict_x7", 32'h5555_5555, 32'h1234_5678, 2'b00, '0, 1'b1);
        sample_all();
        tick();
        idle();
        expect_all("stored_x7", 32'h5555_5555, 32'h1234_5678, 2'b00, '0, 1'b0);
        sample_all();
        tick();

        // x0 write/alloc ignored; both ports on x0 do not count as conflict.
        rd(0, 0); rd(1, 7);
        wr(0, 0, 32'hFFFF_FFFF);
        wr(1, 0, 32'hFFFF_FFFF);
        alloc(0);
        expect_all("x0_write", '0, 32'h5555_5555, 2'b00, '0, 1'b0);
        sample_all();
        tick();
        idle();
        expect_all("x0_after", '0, 32'h5555_5555, 2'b00, '0, 1'b0);
        sample_all();
        tick();

        // Scoreboard on x3: alloc, write-clear, alloc+write.
        rd(0, 3); rd(1, 5);
        alloc(3);
        expect_all("alloc_x3", '0, 32'h1234_5678, 2'b00, '0, 1'b0);
        sample_all();
        tick();
        idle();
        expect_all("busy_x3", '0, 32'h1234_5678, 2'b01, 32'h0000_0008, 1'b0);
        sample_all();
        tick();
        wr(1, 3, 32'h42);
        expect_all("wr_x3", 32'h42, 32'h1234_5678, 2'b00, 32'h0000_0008, 1'b0);
        sample_all();
        tick();
        idle();
        expect_all("clr_x3", 32'h42, 32'h1234_5678, 2'b00, '0, 1'b0);
        sample_all();
        tick();
        alloc(3);
        wr(0, 3, 32'h43);
        expect_all("alwr_x3", 32'h43, 32'h1234_5678, 2'b00, '0, 1'b0);
        sample_all();
        tick();
        idle();
        expect_all("alwr_x3_after", 32'h43, 32'h1234_5678, 2'b01, 32'h0000_0008, 1'b0);
        sample_all();
        tick();

        // Independent writes to x31 and x10 on both read ports.
        rd(0, 31); rd(1, 10);
        wr(0, 10, 32'h0000_0A0A);
        wr(1, 31, 32'hDEAD_BEEF);
        expect_all("two_wr", 32'hDEAD_BEEF, 32'h0000_0A0A, 2'b00, 32'h0000_0008, 1'b0);
        sample_all();
        tick();
        idle();
        expect_all("two_wr_after", 32'hDEAD_BEEF, 32'h0000_0A0A, 2'b00, 32'h0000_0008, 1'b0);
        sample_all();
        tick();

        // x9 alloc+write, then reset with a write in flight.
        rd(0, 9); rd(1, 3);
        alloc(9);
        wr(0, 9, 32'h99);
        expect_all("x9_alwr", 32'h99, 32'h43, 2'b10, 32'h0000_0008, 1'b0);
        sample_all();
        tick();
        idle();
        i_reset = 1'b1;
        wr(0, 9, 32'h77);
        wr(1, 9, 32'h88);
        expect_all("x9_in_reset", 32'h99, 32'h43, 2'b10, 32'h0000_0208, 1'b1);
        sample_all();
        tick();
        i_reset = 1'b0;
        idle();
        expect_all("x9_post_reset", '0, '0, 2'b00, '0, 1'b0);
        sample_all();
        tick();
        rd(0, 31); rd(1, 5);
        expect_all("post_reset_misc", '0, '0, 2'b00, '0, 1'b0);
        sample_all();

        if (sb.size() != 0) begin
            n_asserts++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
